seg7_scan_driver: RTL and testbench

//  Parametrised N-digit 7-segment display driver for the stopwatch/clock designs.

---
 rtl/seg7_scan_driver.sv | 155 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// N-digit 7-segment driver: latched shadow digits, hex/BCD decode, leading-zero
// blanking and blink, driving both a static per-digit bus and a multiplexed bus.
module seg7_scan_driver #(
  parameter int N_DIGITS = 6,
  parameter int CLK_HZ   = 50_000_000,
  parameter int SCAN_HZ  = 6_000,
  parameter int BLINK_HZ = 2,
  parameter int HEX_EN   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [4*N_DIGITS-1:0]     digits_in,
  input  logic [N_DIGITS-1:0]       dp_in,
  input  logic [N_DIGITS-1:0]       blink_mask,
  input  logic                      lz_blank,
  output logic [7*N_DIGITS-1:0]     seg_all,
  output logic [N_DIGITS-1:0]       dp_all,
  output logic [6:0]                seg_out,
  output logic                      dp_out,
  output logic [N_DIGITS-1:0]       an_out,
  output logic [((N_DIGITS > 1) ? $clog2(N_DIGITS) : 1)-1:0] scan_idx
);

  localparam int IDX_W     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int DIV_SCAN  = CLK_HZ / SCAN_HZ;
  localparam int DIV_BLINK = CLK_HZ / (2 * BLINK_HZ);
  localparam int SCAN_W    = $clog2(DIV_SCAN);
  localparam int BLINK_W   = (DIV_BLINK > 1) ? $clog2(DIV_BLINK) : 1;

  logic [4*N_DIGITS-1:0] digits_q;
  logic [N_DIGITS-1:0]   dp_q;
  logic [N_DIGITS-1:0]   blink_q;

  logic [SCAN_W-1:0]     scan_cnt;
  logic [SCAN_W-1:0]     scan_cnt_nx;
  logic [IDX_W-1:0]      scan_idx_nx;
  logic [BLINK_W-1:0]    blink_cnt;
  logic [BLINK_W-1:0]    blink_cnt_nx;
  logic                  blink_phase;
  logic                  blink_phase_nx;

  logic [7*N_DIGITS-1:0] seg_nx;
  logic [N_DIGITS-1:0]   dp_nx;
  logic                  upper_zero;
  logic                  lz_hit;
  logic [6:0]            seg_mux;
  logic                  dp_mux;
  logic [N_DIGITS-1:0]   an_nx;

  // Segment patterns a..g (MSB..LSB), active-low.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    if (HEX_EN == 0 && nib > 4'd9) s = 7'b1111111;
    return s;
  endfunction

  // Walk from the top digit down so blanking stops at the first non-zero digit.
  always_comb begin
    seg_nx     = '1;
    dp_nx      = '1;
    upper_zero = 1'b1;
    lz_hit     = 1'b0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (digits_q[4*i +: 4] == 4'd0);
      lz_hit     = lz_blank && (i != 0) && upper_zero;
      if (!(blink_phase && blink_q[i])) begin
        seg_nx[7*i +: 7] = lz_hit ? 7'b1111111 : decode(digits_q[4*i +: 4]);
        dp_nx[i]         = ~dp_q[i];
      end
    end
  end

  always_comb begin
    scan_cnt_nx    = scan_cnt + SCAN_W'(1);
    scan_idx_nx    = scan_idx;
    blink_cnt_nx   = blink_cnt + BLINK_W'(1);
    blink_phase_nx = blink_phase;
    if (scan_cnt == SCAN_W'(DIV_SCAN - 1)) begin
      scan_cnt_nx = '0;
      scan_idx_nx = (scan_idx == IDX_W'(N_DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
    end
    if (blink_cnt == BLINK_W'(DIV_BLINK - 1)) begin
      blink_cnt_nx   = '0;
      blink_phase_nx = ~blink_phase;
    end
  end

  // Mux the freshly decoded digit so seg_out always equals the seg_all slice on the same cycle.
  always_comb begin
    seg_mux = 7'b1111111;
    dp_mux  = 1'b1;
    an_nx   = '1;
    if (scan_cnt_nx != '0) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (scan_idx_nx == IDX_W'(i)) begin
          seg_mux  = seg_nx[7*i +: 7];
          dp_mux   = dp_nx[i];
          an_nx[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digits_q    <= '0;
      dp_q        <= '0;
      blink_q     <= '0;
      scan_cnt    <= '0;
      scan_idx    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      seg_all     <= '1;
      dp_all      <= '1;
      seg_out     <= '1;
      dp_out      <= 1'b1;
      an_out      <= '1;
    end else begin
      if (load) begin
        digits_q <= digits_in;
        dp_q     <= dp_in;
        blink_q  <= blink_mask;
      end
      scan_cnt    <= scan_cnt_nx;
      scan_idx    <= scan_idx_nx;
      blink_cnt   <= blink_cnt_nx;
      blink_phase <= blink_phase_nx;
      seg_all     <= seg_nx;
      dp_all      <= dp_nx;
      seg_out     <= seg_mux;
      dp_out      <= dp_mux;
      an_out      <= an_nx;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: stimulus pushes model predictions,
// a monitor pops and compares one entry per clock.
module tb_seg7_scan_driver;

  localparam int N         = 6;
  localparam int DIV_SCAN  = 4;
  localparam int DIV_BLINK = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [23:0] digits_in;
  logic [5:0]  dp_in;
  logic [5:0]  blink_mask;
  logic        lz_blank;
  logic [41:0] seg_all;
  logic [5:0]  dp_all;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [5:0]  an_out;
  logic [2:0]  scan_idx;
  logic [41:0] seg_all_nh;
  logic [5:0]  dp_all_nh;
  logic [6:0]  seg_out_nh;
  logic        dp_out_nh;
  logic [5:0]  an_out_nh;
  logic [2:0]  scan_idx_nh;

  always #5 clk = ~clk;

  seg7_scan_driver #(.N_DIGITS(6), .CLK_HZ(24), .SCAN_HZ(6), .BLINK_HZ(2), .HEX_EN(1)) u_dut (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .blink_mask(blink_mask), .lz_blank(lz_blank), .seg_all(seg_all), .dp_all(dp_all),
    .seg_out(seg_out), .dp_out(dp_out), .an_out(an_out), .scan_idx(scan_idx)
  );

  seg7_scan_driver #(.N_DIGITS(6), .CLK_HZ(24), .SCAN_HZ(6), .BLINK_HZ(2), .HEX_EN(0)) u_dut_nohex (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .blink_mask(blink_mask), .lz_blank(lz_blank), .seg_all(seg_all_nh), .dp_all(dp_all_nh),
    .seg_out(seg_out_nh), .dp_out(dp_out_nh), .an_out(an_out_nh), .scan_idx(scan_idx_nh)
  );

  typedef struct {
    logic [41:0] seg;
    logic [5:0]  dp;
    logic [41:0] seg_nh;
    logic [5:0]  an;
    int          idx;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: last loaded values and number of clock edges since reset release.
  int   m_edge = 0;
  int   m_dig[N];
  bit   m_dp[N];
  bit   m_blink[N];

  function automatic logic [6:0] seg_of(input int v, input bit hex);
    case (v)
      0: return 7'b0000001;   1: return 7'b1001111;   2: return 7'b0010010;
      3: return 7'b0000110;   4: return 7'b1001100;   5: return 7'b0100100;
      6: return 7'b0100000;   7: return 7'b0001111;   8: return 7'b0000000;
      9: return 7'b0000100;
      default: ;
    endcase
    if (!hex) return 7'b1111111;
    case (v)
      10: return 7'b0001000;  11: return 7'b1100000;  12: return 7'b0110001;
      13: return 7'b1000010;  14: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic resetModel();
    m_edge = 0;
    for (int i = 0; i < N; i++) begin
      m_dig[i]   = 0;
      m_dp[i]    = 1'b0;
      m_blink[i] = 1'b0;
    end
  endtask

  // Drives one clock's worth of inputs and predicts the outputs after the coming edge.
  task automatic applyStimulus(input bit ld, input logic [23:0] dig, input logic [5:0] dp,
                               input logic [5:0] mask, input bit lz);
    exp_t e;
    int   m;
    int   hi;
    int   scnt;
    bit   phase;
    bit   blank;
    @(negedge clk);
    load       = ld;
    digits_in  = dig;
    dp_in      = dp;
    blink_mask = mask;
    lz_blank   = lz;
    m     = m_edge + 1;
    phase = (((m - 1) / DIV_BLINK) % 2) == 1;
    hi    = -1;
    for (int i = 0; i < N; i++) if (m_dig[i] != 0) hi = i;
    e.seg    = '1;
    e.seg_nh = '1;
    e.dp     = '1;
    for (int i = 0; i < N; i++) begin
      if (!(phase && m_blink[i])) begin
        blank = lz && (i > 0) && (i > hi);
        e.seg[7*i +: 7]    = blank ? 7'b1111111 : seg_of(m_dig[i], 1'b1);
        e.seg_nh[7*i +: 7] = blank ? 7'b1111111 : seg_of(m_dig[i], 1'b0);
        e.dp[i]            = ~m_dp[i];
      end
    end
    scnt  = m % DIV_SCAN;
    e.idx = (m / DIV_SCAN) % N;
    e.an  = '1;
    if (scnt != 0) e.an[e.idx] = 1'b0;
    sb.push_back(e);
    if (ld) begin
      for (int i = 0; i < N; i++) begin
        m_dig[i]   = int'(dig[4*i +: 4]);
        m_dp[i]    = dp[i];
        m_blink[i] = mask[i];
      end
    end
    m_edge = m;
  endtask

  // Monitor: outputs are valid every clock out of reset; compare one scoreboard entry per edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checkOutput("seg_all",    64'(seg_all),    64'(mon_e.seg));
      checkOutput("dp_all",     64'(dp_all),     64'(mon_e.dp));
      checkOutput("seg_all_nh", 64'(seg_all_nh), 64'(mon_e.seg_nh));
      checkOutput("an_out",     64'(an_out),     64'(mon_e.an));
      checkOutput("scan_idx",   64'(scan_idx),   64'(mon_e.idx));
      if (mon_e.an != 6'h3F) begin
        checkOutput("seg_out", 64'(seg_out), 64'(mon_e.seg[7*mon_e.idx +: 7]));
        checkOutput("dp_out",  64'(dp_out),  64'(mon_e.dp[mon_e.idx]));
      end
    end
  end

  task automatic checkDark(input string tag);
    checkOutput({tag, "_seg_all"}, 64'(seg_all), 64'({42{1'b1}}));
    checkOutput({tag, "_dp_all"},  64'(dp_all),  64'(6'h3F));
    checkOutput({tag, "_seg_out"}, 64'(seg_out), 64'(7'h7F));
    checkOutput({tag, "_dp_out"},  64'(dp_out),  64'(1'b1));
    checkOutput({tag, "_an_out"},  64'(an_out),  64'(6'h3F));
  endtask

  initial begin
    int guard;
    logic [23:0] rd;
    rst = 1'b0; load = 1'b0; digits_in = '0; dp_in = '0; blink_mask = '0; lz_blank = 1'b0;
    resetModel();
    repeat (3) @(posedge clk);
    #2;
    checkDark("reset_held");
    checkOutput("reset_scan_idx", 64'(scan_idx), 64'(0));
    rst = 1'b1;

    applyStimulus(1'b0, 24'h0, 6'h0, 6'h0, 1'b0);
    @(posedge clk);
    #2;
    checkOutput("release_seg_all", 64'(seg_all), 64'({6{7'b0000001}}));
    checkOutput("release_dp_all",  64'(dp_all),  64'(6'h3F));

    applyStimulus(1'b1, 24'h123456, 6'h0, 6'h0, 1'b0);
    applyStimulus(1'b0, 24'h0, 6'h0, 6'h0, 1'b0);
    @(posedge clk);
    #2;
    checkOutput("dir_digit0_6", 64'(seg_all[6:0]),   64'(7'b0100000));
    checkOutput("dir_digit5_1", 64'(seg_all[41:35]), 64'(7'b1001111));

    applyStimulus(1'b1, 24'h00000A, 6'h0, 6'h0, 1'b1);
    applyStimulus(1'b0, 24'h0, 6'h0, 6'h0, 1'b1);
    @(posedge clk);
    #2;
    checkOutput("dir_hexA",     64'(seg_all[6:0]),    64'(7'b0001000));
    checkOutput("dir_lz_upper", 64'(seg_all[41:7]),   64'({35{1'b1}}));
    checkOutput("dir_nohexA",   64'(seg_all_nh[6:0]), 64'(7'b1111111));

    applyStimulus(1'b1, 24'h000008, 6'b000001, 6'b000001, 1'b0);
    repeat (4 * DIV_BLINK) applyStimulus(1'b0, 24'h0, 6'h0, 6'h0, 1'b0);

    for (int k = 0; k < 300; k++) begin
      for (int d = 0; d < N; d++)
        rd[4*d +: 4] = ($urandom_range(2) == 0) ? 4'd0 : 4'($urandom_range(15));
      applyStimulus($urandom_range(3) == 0, rd, 6'($urandom_range(63)),
                    ($urandom_range(3) == 0) ? 6'($urandom_range(63)) : 6'h0,
                    1'($urandom_range(1)));
    end

    guard = 0;
    while (!(((m_edge / DIV_SCAN) % N) == 3 && (m_edge % DIV_SCAN) == 2) && guard < 100) begin
      applyStimulus(1'b0, 24'h0, 6'h0, 6'h0, 1'b0);
      guard++;
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkDark("async_reset");
    checkOutput("async_reset_idx", 64'(scan_idx), 64'(0));
    sb.delete();
    resetModel();
    repeat (2) @(posedge clk);
    #2;
    checkDark("reset_hold2");
    rst = 1'b1;
    repeat (3 * DIV_SCAN * N) applyStimulus(1'b0, 24'h0, 6'h0, 6'h0, 1'b0);

    repeat (2) @(posedge clk);
    #3;
    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
